// File: rtl/imem_fetch_unit_pkg.sv
// Shared types and constants for the DLX instruction fetch stage.
// The fetch entry pairs each buffered instruction with the byte PC it was fetched from.
package dlx_fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam int PAIR_BYTES  = 8;

    typedef enum logic {
        WAIT = 1'b0,
        REQ  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(INSTR_BYTES - 1);
    endfunction

    function automatic logic [XLEN-1:0] pair_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(PAIR_BYTES - 1);
    endfunction

endpackage

// File: rtl/imem_fetch_unit_if.sv
// Bundle of the fetch stage's external signals: instruction memory port,
// decode-side valid/ready handshake and the execute-stage redirect.
interface imem_fetch_unit_if #(
    parameter int WORD_SIZE = 32
);
    logic [WORD_SIZE-1:0]   mem_address;
    logic                   mem_enable;
    logic                   mem_data_ready;
    logic [2*WORD_SIZE-1:0] mem_data;
    logic [WORD_SIZE-1:0]   instr;
    logic [WORD_SIZE-1:0]   instr_pc;
    logic                   instr_valid;
    logic                   instr_ready;
    logic                   redirect_valid;
    logic [WORD_SIZE-1:0]   redirect_pc;

    modport master (
        output mem_address, mem_enable, instr, instr_pc, instr_valid,
        input  mem_data_ready, mem_data, instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_address, mem_enable, instr, instr_pc, instr_valid,
        output mem_data_ready, mem_data, instr_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/imem_fetch_unit_fifo.sv
// Instruction buffer: accepts one or two entries per cycle, pops one, flushes in one cycle.
// The caller guarantees a push never exceeds the free space.
module fetch_fifo
    import dlx_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [1:0]                    push_count,
    input  fetch_entry_t                  push_first,
    input  fetch_entry_t                  push_second,
    input  logic                          pop,
    output fetch_entry_t                  head,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    fetch_entry_t           slots [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   do_pop;

    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    // Slot contents are undefined while empty, so the head is masked to zero.
    assign head   = empty ? '0 : slots[rd_ptr];

    // NOTE: the storage array is deliberately not reset; only pointers and count are,
    // which keeps it a plain RAM and makes its contents unobservable until written.
    always_ff @(posedge clk) begin
        if (push_count != 2'd0) begin
            slots[wr_ptr] <= push_first;
        end
        if (push_count == 2'd2) begin
            slots[wr_ptr + PTR_ONE] <= push_second;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push_count);
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count + CNT_W'(push_count) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/imem_fetch_unit.sv
// DLX instruction fetch: requests word pairs from instruction memory, splits them into
// two instructions, buffers them with their PCs and serves decode; redirects flush everything.
module imem_fetch_unit
    import dlx_fetch_pkg::*;
#(
    parameter int                   WORD_SIZE  = XLEN,
    parameter int                   FIFO_DEPTH = 4,
    parameter logic [WORD_SIZE-1:0] RESET_PC   = '0
) (
    input logic               clk,
    input logic               rst,
    imem_fetch_unit_if.master bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t           state;
    fetch_state_t           state_next;
    logic [WORD_SIZE-1:0]   fetch_pc;
    logic                   skip_lo;
    logic                   capture;
    logic                   pop;
    logic                   has_room;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic [1:0]             push_count;
    fetch_entry_t           push_first;
    fetch_entry_t           push_second;
    fetch_entry_t           head;
    logic                   mem_enable;
    logic [WORD_SIZE-1:0]   mem_address;

    // Redirect wins over a returning pair and over a decode pop in the same cycle.
    assign capture  = (state == REQ) && bus.mem_data_ready && !bus.redirect_valid;
    assign pop      = !fifo_empty && bus.instr_ready && !bus.redirect_valid;
    assign has_room = (CNT_W'(FIFO_DEPTH) - fifo_count) >= CNT_W'(2);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= WAIT;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        if (bus.redirect_valid) begin
            state_next = WAIT;
        end else begin
            case (state)
                WAIT:    if (has_room) state_next = REQ;
                REQ:     if (bus.mem_data_ready) state_next = WAIT;
                default: state_next = WAIT;
            endcase
        end
    end

    always_comb begin
        mem_enable  = 1'b0;
        mem_address = '0;
        if (state == REQ) begin
            mem_enable  = 1'b1;
            mem_address = {2'b00, fetch_pc[WORD_SIZE-1:3], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= word_align(RESET_PC);
            skip_lo  <= RESET_PC[2];
        end else if (bus.redirect_valid) begin
            fetch_pc <= word_align(bus.redirect_pc);
            skip_lo  <= bus.redirect_pc[2];
        end else if (capture) begin
            fetch_pc <= pair_align(fetch_pc) + WORD_SIZE'(PAIR_BYTES);
            skip_lo  <= 1'b0;
        end
    end

    // An odd target word means the low half of the returned pair precedes it and is dropped.
    always_comb begin
        push_count  = 2'd0;
        push_first  = '0;
        push_second = '0;
        if (capture) begin
            if (skip_lo) begin
                push_count  = 2'd1;
                push_first  = '{pc: fetch_pc, instr: bus.mem_data[2*WORD_SIZE-1:WORD_SIZE]};
            end else begin
                push_count  = 2'd2;
                push_first  = '{pc: fetch_pc, instr: bus.mem_data[WORD_SIZE-1:0]};
                push_second = '{pc: fetch_pc + WORD_SIZE'(INSTR_BYTES),
                                instr: bus.mem_data[2*WORD_SIZE-1:WORD_SIZE]};
            end
        end
    end

    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush       (bus.redirect_valid),
        .push_count  (push_count),
        .push_first  (push_first),
        .push_second (push_second),
        .pop         (pop),
        .head        (head),
        .empty       (fifo_empty),
        .count       (fifo_count)
    );

    assign bus.mem_enable  = mem_enable;
    assign bus.mem_address = mem_address;
    assign bus.instr       = head.instr;
    assign bus.instr_pc    = head.pc;
    assign bus.instr_valid = !fifo_empty;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit: two instances (RESET_PC 0 and 0xFFFF_FFF8) each
// served by a delay-2 instruction memory holding word[i] = 0x1000_0000 + i.
module tb_imem_fetch_unit;

    localparam int MEM_D = 2;

    typedef struct {
        int          stall;
        logic [31:0] pc;
        logic [31:0] ins;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;
    int   cnt0 = 0;
    int   cnt1 = 0;
    logic gap_pending = 1'b0;
    logic [31:0] addr_log1 [$];

    always #5 clk = ~clk;

    imem_fetch_unit_if #(.WORD_SIZE(32)) b0 ();
    imem_fetch_unit_if #(.WORD_SIZE(32)) b1 ();

    imem_fetch_unit #(.WORD_SIZE(32), .FIFO_DEPTH(4), .RESET_PC(32'h0000_0000)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    imem_fetch_unit #(.WORD_SIZE(32), .FIFO_DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    function automatic logic [31:0] word_at(input logic [31:0] idx);
        return 32'h1000_0000 + idx;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Memory models: ready is raised on the (MEM_D+1)th enabled edge and held until enable drops.
    always @(posedge clk) begin
        #1;
        if (b0.mem_enable === 1'b1) begin
            if (cnt0 == MEM_D) begin
                b0.mem_data_ready = 1'b1;
                b0.mem_data = {word_at(b0.mem_address + 32'd1), word_at(b0.mem_address)};
            end else begin
                cnt0++;
            end
        end else begin
            b0.mem_data_ready = 1'b0;
            b0.mem_data       = 'z;
            cnt0              = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (b1.mem_enable === 1'b1) begin
            if (cnt1 == MEM_D) begin
                if (b1.mem_data_ready !== 1'b1) addr_log1.push_back(b1.mem_address);
                b1.mem_data_ready = 1'b1;
                b1.mem_data = {word_at(b1.mem_address + 32'd1), word_at(b1.mem_address)};
            end else begin
                cnt1++;
            end
        end else begin
            b1.mem_data_ready = 1'b0;
            b1.mem_data       = 'z;
            cnt1              = 0;
        end
    end

    // After every capture the enable must drop for at least one cycle.
    always @(negedge clk) begin
        if (gap_pending) check("enable_gap", 64'(b0.mem_enable), 64'd0);
        gap_pending = (b0.mem_enable === 1'b1) && (b0.mem_data_ready === 1'b1);
    end

    function automatic logic rd_valid(input int which);
        return (which == 0) ? b0.instr_valid : b1.instr_valid;
    endfunction

    function automatic logic [31:0] rd_instr(input int which);
        return (which == 0) ? b0.instr : b1.instr;
    endfunction

    function automatic logic [31:0] rd_pc(input int which);
        return (which == 0) ? b0.instr_pc : b1.instr_pc;
    endfunction

    task automatic set_ready(input int which, input logic v);
        if (which == 0) b0.instr_ready = v;
        else            b1.instr_ready = v;
    endtask

    // Waits (bounded) for a valid head, checks it, and pops exactly that one entry.
    task automatic pop_one(input int which, input int stall, input logic [31:0] exp_pc,
                           input logic [31:0] exp_ins, input string name);
        bit got = 1'b0;
        set_ready(which, 1'b0);
        repeat (stall) @(negedge clk);
        for (int c = 0; c < 200 && !got; c++) begin
            if (rd_valid(which) === 1'b1) begin
                check({name, "_instr"}, 64'(rd_instr(which)), 64'(exp_ins));
                check({name, "_pc"}, 64'(rd_pc(which)), 64'(exp_pc));
                set_ready(which, 1'b1);
                @(negedge clk);
                set_ready(which, 1'b0);
                got = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_for(input int what, input string name);
        bit hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            case (what)
                0: hit = (b0.mem_enable === 1'b1) && (b0.instr_valid === 1'b1) &&
                         (b0.mem_data_ready === 1'b0);
                1: hit = (b0.mem_data_ready === 1'b1);
                default: hit = (b0.mem_enable === 1'b1);
            endcase
            if (!hit) @(negedge clk);
        end
        if (!hit) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [8];
        int   bad;

        for (int i = 0; i < 8; i++) begin
            vecs[i].pc  = 32'(i * 4);
            vecs[i].ins = 32'h1000_0000 + 32'(i);
        end
        vecs[0].stall = 0; vecs[1].stall = 0; vecs[2].stall = 2; vecs[3].stall = 0;
        vecs[4].stall = 0; vecs[5].stall = 5; vecs[6].stall = 1; vecs[7].stall = 0;

        b0.instr_ready = 1'b0; b0.redirect_valid = 1'b0; b0.redirect_pc = '0;
        b1.instr_ready = 1'b0; b1.redirect_valid = 1'b0; b1.redirect_pc = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_enable",  64'(b0.mem_enable),  64'd0);
        check("rst_mem_address", 64'(b0.mem_address), 64'd0);
        check("rst_instr_valid", 64'(b0.instr_valid), 64'd0);
        check("rst_instr",       64'(b0.instr),       64'd0);
        check("rst_instr_pc",    64'(b0.instr_pc),    64'd0);
        check("rst_mem_address_hi", 64'(b1.mem_address), 64'd0);
        rst = 1'b1;

        // One mandatory WAIT cycle, then the first request
        @(negedge clk);
        check("first_req_enable",  64'(b0.mem_enable),  64'd1);
        check("first_req_address", 64'(b0.mem_address), 64'd0);
        check("hi_req_address",    64'(b1.mem_address), 64'h3FFF_FFFE);

        for (int i = 0; i < 8; i++) begin
            pop_one(0, vecs[i].stall, vecs[i].pc, vecs[i].ins, "stream");
        end

        // Decode stalled: FIFO fills, fetch stops, head is stable
        repeat (30) @(negedge clk);
        check("full_valid",  64'(b0.instr_valid), 64'd1);
        check("full_instr",  64'(b0.instr),       64'h1000_0008);
        check("full_pc",     64'(b0.instr_pc),    64'h20);
        check("full_enable", 64'(b0.mem_enable),  64'd0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (b0.mem_enable !== 1'b0 || b0.instr !== 32'h1000_0008) bad++;
        end
        check("full_hold", 64'(bad), 64'd0);
        for (int i = 8; i < 12; i++) begin
            pop_one(0, 0, 32'(i * 4), 32'h1000_0000 + 32'(i), "drain");
        end
        check("fifo_exactly_depth", 64'(b0.instr_valid), 64'd0);

        // Redirect to an odd word while a request is outstanding
        wait_for(0, "redir_req");
        b0.redirect_valid = 1'b1;
        b0.redirect_pc    = 32'h0000_0014;
        @(negedge clk);
        b0.redirect_valid = 1'b0;
        check("redir_flush",  64'(b0.instr_valid), 64'd0);
        check("redir_enable", 64'(b0.mem_enable),  64'd0);
        wait_for(2, "redir_refetch");
        check("redir_address", 64'(b0.mem_address), 64'd4);
        pop_one(0, 0, 32'h14, 32'h1000_0005, "redir_a");
        pop_one(0, 0, 32'h18, 32'h1000_0006, "redir_b");
        pop_one(0, 0, 32'h1C, 32'h1000_0007, "redir_c");

        // Redirect coinciding with the ready strobe; low PC bits are ignored
        wait_for(1, "redir_ready");
        b0.redirect_valid = 1'b1;
        b0.redirect_pc    = 32'h0000_0042;
        @(negedge clk);
        b0.redirect_valid = 1'b0;
        check("redir_rdy_flush", 64'(b0.instr_valid), 64'd0);
        pop_one(0, 0, 32'h40, 32'h1000_0010, "redir_rdy_a");
        pop_one(0, 0, 32'h44, 32'h1000_0011, "redir_rdy_b");

        // Top-of-address-space start and wrap
        check("wrap_req_count", 64'(addr_log1.size()), 64'd2);
        check("wrap_addr0", 64'((addr_log1.size() >= 1) ? addr_log1[0] : 32'hDEAD_BEEF),
              64'h3FFF_FFFE);
        check("wrap_addr1", 64'((addr_log1.size() >= 2) ? addr_log1[1] : 32'hDEAD_BEEF),
              64'd0);
        pop_one(1, 0, 32'hFFFF_FFF8, 32'h4FFF_FFFE, "wrap_a");
        pop_one(1, 0, 32'hFFFF_FFFC, 32'h4FFF_FFFF, "wrap_b");
        pop_one(1, 0, 32'h0000_0000, 32'h1000_0000, "wrap_c");
        pop_one(1, 0, 32'h0000_0004, 32'h1000_0001, "wrap_d");

        // Reset while data is returning
        b0.instr_ready = 1'b0;
        wait_for(1, "rst_req");
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst_enable",  64'(b0.mem_enable),  64'd0);
        check("midrst_address", 64'(b0.mem_address), 64'd0);
        check("midrst_valid",   64'(b0.instr_valid), 64'd0);
        check("midrst_instr",   64'(b0.instr),       64'd0);
        check("midrst_pc",      64'(b0.instr_pc),    64'd0);
        @(negedge clk);
        check("midrst_no_stale", 64'(b0.instr_valid), 64'd0);
        check("midrst_restart",  64'(b0.mem_enable),  64'd1);
        pop_one(0, 0, 32'h0, 32'h1000_0000, "midrst_first");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imem_fetch_unit.md
# imem_fetch_unit

Instruction fetch stage of the DLX core, sitting directly upstream of the instruction read-only memory. It drives the memory's word address and enable, waits for its ready strobe, and splits each returned double word into two 32-bit instructions. It buffers those instructions in a small FIFO and presents them, tagged with their PC, to the decode stage over a valid/ready handshake. It also accepts branch/jump redirects from execute, which flush the buffer and abort any in-flight fetch.

## Interface
Parameters:
- WORD_SIZE, 32, instruction and PC width
- FIFO_DEPTH, 4, instruction slots; power of two, ≥ 2
- RESET_PC, 0, byte address of first fetch

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; one clock, synchronous, active-low
- mem_address  out  WORD_SIZE  word index to instruction memory
- mem_enable  out  1  fetch request to instruction memory
- mem_data_ready  in  1  memory strobe: mem_data valid this cycle
- mem_data  in  2*WORD_SIZE  {word[A+1], word[A]}; high-Z unless mem_data_ready
- instr  out  WORD_SIZE  head-of-FIFO instruction
- instr_pc  out  WORD_SIZE  byte PC of instr
- instr_valid  out  1  FIFO non-empty
- instr_ready  in  1  decode accepts instr
- redirect_valid  in  1  one-cycle redirect request
- redirect_pc  in  WORD_SIZE  redirect target byte address; bits [1:0] ignored

## Operation
- fetch_pc is a byte address. mem_address = {2'b0, fetch_pc[WORD_SIZE-1:3], 1'b0}, the even word index of the pair.
- skip_lo flag: set when the target word index is odd. The lower word of that pair is discarded.
- States:
  - WAIT: mem_enable=0. Go to REQ when free slots ≥ 2.
  - REQ: mem_enable=1, mem_address held stable. On mem_data_ready=1, capture and go to WAIT.
- WAIT always lasts ≥ 1 cycle, because the memory only clears its ready strobe when enable is low.
- Capture behaviour:
  - Normal: push word[A] with PC fetch_pc, then word[A+1] with PC fetch_pc+4.
  - skip_lo set: push only word[A+1], then clear skip_lo.
  - In both cases fetch_pc advances to the next aligned pair (+8, aligned), with modulo-2^WORD_SIZE wrap.
- FIFO entries are {pc, instr}. instr_valid = ~empty. A pop happens on instr_valid & instr_ready.
- A push and a pop in the same cycle are both performed.
- The free-slot count uses the registered occupancy and does not count a same-cycle pop.
- mem_data is sampled only when mem_data_ready=1; it is never inspected otherwise.
- Redirect has priority over everything:
  - Flush the FIFO and ignore any pop that cycle.
  - Discard any mem_data_ready arriving in the same cycle.
  - Load fetch_pc from redirect_pc[WORD_SIZE-1:2] and set skip_lo = redirect_pc[2].
  - Force WAIT.
- Redirect while in WAIT behaves the same way: target loaded, buffer flushed.

## Timing
- Reset values: mem_enable=0, mem_address=0, instr_valid=0, instr=0, instr_pc=0, state=WAIT, FIFO empty, fetch_pc=RESET_PC, skip_lo=RESET_PC[2].
- rst low for one edge is sufficient. Reset mid-REQ drops mem_enable on the next cycle and discards any returning data.
- First mem_enable=1 appears in the second cycle after rst is released, because one WAIT cycle is mandatory.
- Pushed instructions are visible on instr/instr_valid in the cycle after the capture edge. There is no combinational path from mem_data to instr.
- Peak throughput with memory delay D (ready on the D+1th enabled edge): 2 instructions per D+2 cycles.
- No combinational path from instr_ready or redirect_valid to mem_enable. Both outputs are registered.
- Full FIFO with instr_ready=0: stays in WAIT indefinitely and mem_enable stays 0. Contents and instr_valid are unchanged.

## Structure
- Package dlx_fetch_pkg:
  - fetch_state_t enum {WAIT, REQ}
  - INSTR_BYTES=4 and PAIR_BYTES=8 constants
  - fetch_entry_t packed struct {pc, instr}
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push of 1 or 2 entries, pop of 1, flush, and registered count. Parameterised by FIFO_DEPTH.
- The top level holds the FSM, fetch_pc, and skip_lo.

## Test plan
- Reset, then a memory model with D=2 holding word[i]=0x1000_0000+i, instr_ready=1. Required: mem_enable rises on the second cycle after reset; instructions 0x10000000, 0x10000001, … arrive in order with instr_pc 0, 4, 8, …; mem_enable is low for ≥ 1 cycle between requests.
- instr_ready=0 held. Required: exactly FIFO_DEPTH=4 entries buffered, mem_enable stays 0, and instr stays 0x10000000. After release, all 4 drain in order.
- Redirect to 0x0000_0014 (odd word 5) while in REQ. Required: FIFO flushed the next cycle, new mem_address=4, first delivered instruction 0x10000005 with instr_pc 0x14.
- Redirect in the same cycle as mem_data_ready. Required: returned pair discarded; next delivered instr_pc equals the redirect target.
- RESET_PC=0xFFFF_FFF8. Required: pair delivered with PCs 0xFFFFFFF8 and 0xFFFFFFFC, then fetch_pc wraps to 0 and mem_address=0.
- Assert rst during REQ. Required: all outputs return to their reset values after the edge and no stale instruction appears.
